dac_spi_writer: RTL and testbench

DAC_SPI_WRITER -- requirements
Module: dac_spi_writer

---
 rtl/dac_spi_writer.sv | 194 +++++++++++++++++++
 tb/tb_dac_spi_writer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_writer.sv
// dac_spi_writer
//
// Sends one configuration word to a DAC over a mode-0 SPI bus (MSB first),
// then returns a readback word once the frame has completed.
//
// A frame is: SETUP (cs low, first bit on MOSI, CLK_DIV cycles), FRAME_BITS
// SCLK periods of 2*CLK_DIV cycles each, HOLD (cs low, CLK_DIV cycles) and
// GAP (cs high, CS_IDLE cycles). Strobes that arrive while a frame is in
// progress are discarded and reported on drop_o.
//
// Optional feature macro: DAC_READBACK_EN
//   defined   : config_data_o receives the FRAME_BITS bits captured on MISO
//   undefined : dac_miso is unused; config_data_o echoes the transmit word
//
// Parameters
//   CLK_DIV     SCLK half-period in clk cycles (1..255)
//   FRAME_BITS  SPI frame length in bits (8..32)
//   CS_IDLE     clk cycles dac_cs_n stays high after a frame (1..255)
//
// Ports
//   clk             system clock, all logic on its rising edge
//   rst_n           synchronous active-low reset
//   config_data_i   word to send; only bits [FRAME_BITS-1:0] are transmitted
//   config_valid_i  single-cycle strobe qualifying config_data_i
//   config_ready_o  high while idle and able to accept a word
//   config_data_o   readback (or echo) word of the last completed frame
//   frame_done_o    one-cycle pulse when a frame completes
//   drop_o          one-cycle pulse when a strobe is discarded
//   dac_cs_n        SPI chip select, active low
//   dac_sclk        SPI clock, idle low
//   dac_mosi        SPI data to the DAC
//   dac_miso        SPI data from the DAC

module dac_spi_writer #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 24,
  parameter int CS_IDLE    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] config_data_i,
  input  logic        config_valid_i,
  output logic        config_ready_o,
  output logic [31:0] config_data_o,
  output logic        frame_done_o,
  output logic        drop_o,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  input  logic        dac_miso
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(CS_IDLE - 1);
  localparam logic [4:0]  BIT_TOP    = 5'(FRAME_BITS - 1);
  localparam logic [31:0] FRAME_MASK = 32'hFFFF_FFFF >> (32 - FRAME_BITS);

  state_t      state_r;
  logic [7:0]  cnt_r;      // cycles spent in the current phase
  logic [4:0]  bit_idx_r;  // index of the bit currently on MOSI
  logic [31:0] tx_r;       // latched transmit word, zero-extended

`ifdef DAC_READBACK_EN
  logic [31:0] rx_r;       // MISO bits, shifted in MSB first
`else
  logic        unused_miso_s;
  assign unused_miso_s = dac_miso;
`endif

  // Frame sequencer: state, phase counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cnt_r          <= 8'd0;
      bit_idx_r      <= 5'd0;
      tx_r           <= 32'd0;
      config_ready_o <= 1'b1;
      config_data_o  <= 32'd0;
      frame_done_o   <= 1'b0;
      drop_o         <= 1'b0;
      dac_cs_n       <= 1'b1;
      dac_sclk       <= 1'b0;
      dac_mosi       <= 1'b0;
`ifdef DAC_READBACK_EN
      rx_r           <= 32'd0;
`endif
    end else begin
      frame_done_o <= 1'b0;
      // Any strobe seen outside IDLE is discarded; the frame carries on.
      drop_o       <= (state_r != IDLE) ? config_valid_i : 1'b0;

      case (state_r)
        IDLE: begin
          if (config_valid_i) begin
            state_r        <= SETUP;
            cnt_r          <= 8'd0;
            tx_r           <= config_data_i & FRAME_MASK;
            config_ready_o <= 1'b0;
            dac_cs_n       <= 1'b0;
            dac_sclk       <= 1'b0;
            dac_mosi       <= config_data_i[FRAME_BITS-1];
`ifdef DAC_READBACK_EN
            rx_r           <= 32'd0;
`endif
          end
        end

        SETUP: begin
          if (cnt_r == DIV_LAST) begin
            // First rising SCLK edge; MISO is sampled on the same clk edge.
            state_r   <= SHIFT;
            cnt_r     <= 8'd0;
            bit_idx_r <= BIT_TOP;
            dac_sclk  <= 1'b1;
`ifdef DAC_READBACK_EN
            rx_r      <= {rx_r[30:0], dac_miso};
`endif
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end

        SHIFT: begin
          if (cnt_r != DIV_LAST) begin
            cnt_r <= cnt_r + 8'd1;
          end else begin
            cnt_r <= 8'd0;
            if (dac_sclk) begin
              // Falling edge: present the next bit. After bit 0 MOSI just
              // keeps its last value through the low phase.
              dac_sclk <= 1'b0;
              if (bit_idx_r != 5'd0) begin
                dac_mosi <= tx_r[bit_idx_r - 5'd1];
              end
            end else if (bit_idx_r == 5'd0) begin
              // Low phase of the last bit finished.
              state_r <= HOLD;
            end else begin
              bit_idx_r <= bit_idx_r - 5'd1;
              dac_sclk  <= 1'b1;
`ifdef DAC_READBACK_EN
              rx_r      <= {rx_r[30:0], dac_miso};
`endif
            end
          end
        end

        HOLD: begin
          if (cnt_r == DIV_LAST) begin
            state_r  <= GAP;
            cnt_r    <= 8'd0;
            dac_cs_n <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end

        GAP: begin
          if (cnt_r == GAP_LAST) begin
            state_r        <= IDLE;
            cnt_r          <= 8'd0;
            config_ready_o <= 1'b1;
            frame_done_o   <= 1'b1;
`ifdef DAC_READBACK_EN
            config_data_o  <= rx_r & FRAME_MASK;
`else
            config_data_o  <= tx_r;
`endif
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end

        default: begin
          state_r        <= IDLE;
          cnt_r          <= 8'd0;
          config_ready_o <= 1'b1;
          dac_cs_n       <= 1'b1;
          dac_sclk       <= 1'b0;
          dac_mosi       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Self-checking bench for dac_spi_writer (CLK_DIV=2, FRAME_BITS=24, CS_IDLE=2).
// Expected values come from a frame-level model: MOSI carries the low
// FRAME_BITS of the strobed word MSB first, the frame lasts a fixed number of
// cycles, and the readback is either the MISO word or the echoed write.

module tb_dac_spi_writer;

  localparam int CLK_DIV      = 2;
  localparam int FRAME_BITS   = 24;
  localparam int CS_IDLE      = 2;
  localparam int FRAME_CYCLES = 2*CLK_DIV + 2*CLK_DIV*FRAME_BITS + CS_IDLE;
  localparam int BUDGET       = 1000;
  localparam logic [31:0] MASK = 32'((64'd1 << FRAME_BITS) - 64'd1);

  logic        clk;
  logic        rst_n;
  logic [31:0] config_data_i;
  logic        config_valid_i;
  logic        config_ready_o;
  logic [31:0] config_data_o;
  logic        frame_done_o;
  logic        drop_o;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_mosi;
  logic        dac_miso;

  int total = 0;
  int bad   = 0;

  dac_spi_writer #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_BITS(FRAME_BITS),
    .CS_IDLE   (CS_IDLE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .config_data_i (config_data_i),
    .config_valid_i(config_valid_i),
    .config_ready_o(config_ready_o),
    .config_data_o (config_data_o),
    .frame_done_o  (frame_done_o),
    .drop_o        (drop_o),
    .dac_cs_n      (dac_cs_n),
    .dac_sclk      (dac_sclk),
    .dac_mosi      (dac_mosi),
    .dac_miso      (dac_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DAC model: first bit out when cs falls, next bit after every SCLK fall.
  logic [31:0] miso_word = 32'd0;
  int          fall_cnt  = 0;
  logic        miso_prev = 1'b0;
  initial dac_miso = 1'b0;
  always @(negedge clk) begin : miso_model
    int f;
    f = fall_cnt;
    if (dac_cs_n) f = 0;
    else if (miso_prev && !dac_sclk) f = f + 1;
    fall_cnt  <= f;
    miso_prev <= dac_sclk;
    dac_miso  <= (f < FRAME_BITS) ? miso_word[FRAME_BITS-1-f] : 1'b0;
  end

  // Length of the most recent completed run of dac_cs_n high.
  int cs_run   = 0;
  int last_gap = 0;
  always @(negedge clk) begin
    if (dac_cs_n) cs_run <= cs_run + 1;
    else begin
      if (cs_run != 0) last_gap <= cs_run;
      cs_run <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_readback(input logic [31:0] data, input logic [31:0] miso);
`ifdef DAC_READBACK_EN
    return miso & MASK;
`else
    return data & MASK;
`endif
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [31:0] miso;
    int          drop_at;
    logic [31:0] exp_data_o;
    int          exp_drops;
  } vec_t;

  typedef struct {
    int          ready_low;
    int          rises;
    int          done_mid;
    int          drops;
    int          gap_mid;
    logic [31:0] mosi_word;
    logic [31:0] data_end;
    logic        done_end;
    logic        ready_end;
  } res_t;

  // Strobes one word at the current negedge and observes until ready returns.
  // Returns on the negedge where config_ready_o is first seen high again.
  task automatic run_frame(input logic [31:0] data, input int drop_at, output res_t r);
    logic prev;
    int   i;
    r = '{default: 0};
    config_data_i  = data;
    config_valid_i = 1'b1;
    @(negedge clk);
    config_valid_i = 1'b0;
    config_data_i  = $urandom;
    prev = 1'b0;
    i = 0;
    while (config_ready_o == 1'b0 && i < BUDGET) begin
      r.ready_low++;
      if (!prev && dac_sclk) begin
        r.rises++;
        r.mosi_word = {r.mosi_word[30:0], dac_mosi};
      end
      prev = dac_sclk;
      if (frame_done_o) r.done_mid++;
      if (drop_o) r.drops++;
      if (dac_cs_n) r.gap_mid++;
      if (i == drop_at) begin
        config_valid_i = 1'b1;
        config_data_i  = 32'hDEAD_BEEF;
      end else begin
        config_valid_i = 1'b0;
      end
      i++;
      @(negedge clk);
    end
    config_valid_i = 1'b0;
    r.done_end  = frame_done_o;
    r.data_end  = config_data_o;
    r.ready_end = config_ready_o;
  endtask

  task automatic check_frame(input string tag, input vec_t v, input res_t r);
    check({tag, " ready_end"}, 32'(r.ready_end), 32'd1);
    check({tag, " ready_low"}, 32'(r.ready_low), 32'(FRAME_CYCLES));
    check({tag, " sclk_rises"}, 32'(r.rises), 32'(FRAME_BITS));
    check({tag, " mosi_word"}, r.mosi_word, v.data & MASK);
    check({tag, " done_mid"}, 32'(r.done_mid), 32'd0);
    check({tag, " done_end"}, 32'(r.done_end), 32'd1);
    check({tag, " data_o"}, r.data_end, v.exp_data_o);
    check({tag, " drops"}, 32'(r.drops), 32'(v.exp_drops));
    check({tag, " cs_gap"}, 32'(r.gap_mid), 32'(CS_IDLE));
  endtask

  vec_t vecs[6];
  res_t res;
  res_t res2;

  initial begin
    // Vector table: two fixed scenarios, then random words.
    vecs[0].data = 32'hFFA5_5A3C; vecs[0].miso = 32'h0012_3456; vecs[0].drop_at = -1;
`ifdef DAC_READBACK_EN
    vecs[0].exp_data_o = 32'h0012_3456;
`else
    vecs[0].exp_data_o = 32'h00A5_5A3C;
`endif
    vecs[0].exp_drops = 0;
    vecs[1].data = 32'h00C3_0F81; vecs[1].miso = 32'h00AB_CDEF; vecs[1].drop_at = 10;
    vecs[1].exp_data_o = model_readback(32'h00C3_0F81, 32'h00AB_CDEF);
    vecs[1].exp_drops = 1;
    for (int n = 2; n < 6; n++) begin
      vecs[n].data       = $urandom;
      vecs[n].miso       = $urandom;
      vecs[n].drop_at    = (n == 4) ? int'($urandom_range(3, 90)) : -1;
      vecs[n].exp_data_o = model_readback(vecs[n].data, vecs[n].miso);
      vecs[n].exp_drops  = (n == 4) ? 1 : 0;
    end

    rst_n          = 1'b0;
    config_valid_i = 1'b0;
    config_data_i  = 32'd0;
    repeat (3) @(negedge clk);
    check("rst ready", 32'(config_ready_o), 32'd1);
    check("rst data_o", config_data_o, 32'd0);
    check("rst done", 32'(frame_done_o), 32'd0);
    check("rst drop", 32'(drop_o), 32'd0);
    check("rst cs_n", 32'(dac_cs_n), 32'd1);
    check("rst sclk", 32'(dac_sclk), 32'd0);
    check("rst mosi", 32'(dac_mosi), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames.
    for (int n = 0; n < 6; n++) begin
      miso_word = vecs[n].miso;
      run_frame(vecs[n].data, vecs[n].drop_at, res);
      check_frame($sformatf("v%0d", n), vecs[n], res);
      @(negedge clk);
      check($sformatf("v%0d done_width", n), 32'(frame_done_o), 32'd0);
      repeat (3) @(negedge clk);
    end

    // Back-to-back: second strobe in the first ready cycle.
    miso_word = 32'h0055_AA11;
    run_frame(32'h0013_5790, -1, res);
    check("b2b first done", 32'(res.done_end), 32'd1);
    miso_word = 32'h0066_7788;
    run_frame(32'h0024_68AC, -1, res2);
    check("b2b second ready_low", 32'(res2.ready_low), 32'(FRAME_CYCLES));
    check("b2b second mosi", res2.mosi_word, 32'h0024_68AC);
    check("b2b second data_o", res2.data_end, model_readback(32'h0024_68AC, 32'h0066_7788));
    // GAP cycles plus the single ready cycle in which the strobe is taken.
    check("b2b cs_high", 32'(last_gap), 32'(CS_IDLE + 1));
    repeat (3) @(negedge clk);

    // Reset during bit 10 of a frame, with a strobe held during reset.
    begin
      logic prev;
      int   rises;
      int   done_seen;
      int   drop_seen;
      config_data_i  = 32'h00F0_F0F0;
      config_valid_i = 1'b1;
      @(negedge clk);
      config_valid_i = 1'b0;
      prev  = 1'b0;
      rises = 0;
      for (int k = 0; k < BUDGET; k++) begin
        if (!prev && dac_sclk) rises++;
        prev = dac_sclk;
        if (rises == FRAME_BITS - 10) break;
        @(negedge clk);
      end
      check("rstmid reached bit10", 32'(rises), 32'(FRAME_BITS - 10));
      rst_n          = 1'b0;
      config_valid_i = 1'b1;
      @(negedge clk);
      check("rstmid cs_n", 32'(dac_cs_n), 32'd1);
      check("rstmid sclk", 32'(dac_sclk), 32'd0);
      check("rstmid ready", 32'(config_ready_o), 32'd1);
      check("rstmid done", 32'(frame_done_o), 32'd0);
      check("rstmid data_o", config_data_o, 32'd0);
      @(negedge clk);
      check("rstmid drop", 32'(drop_o), 32'd0);
      rst_n          = 1'b1;
      config_valid_i = 1'b0;
      done_seen = 0;
      drop_seen = 0;
      for (int k = 0; k < FRAME_CYCLES + 10; k++) begin
        @(negedge clk);
        if (frame_done_o) done_seen++;
        if (drop_o) drop_seen++;
        if (!dac_cs_n) done_seen++;
      end
      check("rstmid quiet after", 32'(done_seen + drop_seen), 32'd0);
      check("rstmid idle ready", 32'(config_ready_o), 32'd1);
    end

    // Recovery frame after the aborted one.
    miso_word = 32'h0098_7654;
    run_frame(32'h0F0E_0D0C, -1, res);
    vecs[0].data       = 32'h0F0E_0D0C;
    vecs[0].miso       = 32'h0098_7654;
    vecs[0].exp_data_o = model_readback(32'h0F0E_0D0C, 32'h0098_7654);
    vecs[0].exp_drops  = 0;
    check_frame("recover", vecs[0], res);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
